// File: rtl/pipe_regs_pkg.sv
// Shared defaults and helpers for the elastic pipeline register chain.
package pipe_regs_pkg;

  localparam int unsigned DW_DEFAULT    = 32;
  localparam int unsigned DEPTH_DEFAULT = 2;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic stage: valid bit, gated payload register and readiness term.
module pipe_stage
  import pipe_regs_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          src_valid,
  input  logic [DW-1:0] src_data,
  input  logic          next_ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          ready_c
);

  // An empty stage always accepts; a full one accepts only if its item moves on.
  assign ready_c = !valid | next_ready;

  // Valid bit: cleared by flush, otherwise follows the upstream source when ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready_c) begin
      valid <= src_valid;
    end
  end

  // Payload: only written by a real item, so bubbles leave the register quiet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data <= '0;
    end else if (!flush && ready_c && src_valid) begin
      data <= src_data;
    end
  end

endmodule

// File: rtl/pipe_regs.sv
// DEPTH-stage elastic register chain with bubble collapsing, flush and occupancy count.
module pipe_regs
  import pipe_regs_pkg::*;
#(
  parameter  int unsigned DW    = DW_DEFAULT,
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] count
);

  logic          stage_valid [DEPTH];
  logic [DW-1:0] stage_data  [DEPTH];
  logic          stage_ready [DEPTH+1];
  logic          in_xfer;
  logic          out_xfer;

  assign stage_ready[DEPTH] = out_ready;

  // Stage chain; stage 0 is fed from the input port, each later stage from its predecessor.
  for (genvar k = 0; k < int'(DEPTH); k++) begin : g_stage
    logic          src_valid;
    logic [DW-1:0] src_data;

    if (k == 0) begin : g_head
      assign src_valid = in_valid;
      assign src_data  = in_data;
    end else begin : g_body
      assign src_valid = stage_valid[k-1];
      assign src_data  = stage_data[k-1];
    end

    pipe_stage #(
      .DW(DW)
    ) u_stage (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .src_valid (src_valid),
      .src_data  (src_data),
      .next_ready(stage_ready[k+1]),
      .valid     (stage_valid[k]),
      .data      (stage_data[k]),
      .ready_c   (stage_ready[k])
    );
  end

  // Handshake terms; flush blocks both ends in the cycle it is asserted.
  assign in_ready  = stage_ready[0] & !flush;
  assign out_valid = stage_valid[DEPTH-1] & !flush;
  assign out_data  = stage_data[DEPTH-1];
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Occupancy tracks accepted minus delivered items; flush empties the chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_xfer && !out_xfer) begin
      count <= count + CNT_W'(1);
    end else if (out_xfer && !in_xfer) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_regs.sv
// Scoreboard bench for pipe_regs: DEPTH=2 and DEPTH=3 instances share one stimulus stream.
module tb_pipe_regs;

  typedef struct {
    logic [31:0] d;
    int          t;
  } item_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        done = 1'b0;

  logic        irdy [2];
  logic        ovld [2];
  logic [31:0] odat [2];
  logic [1:0]  cnt  [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  item_t q0 [$];
  item_t q1 [$];

  always #5 clk = ~clk;

  pipe_regs #(.DW(32), .DEPTH(2)) u_d2 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[0]), .in_data(in_data),
    .out_valid(ovld[0]), .out_ready(out_ready), .out_data(odat[0]),
    .count(cnt[0])
  );

  pipe_regs #(.DW(32), .DEPTH(3)) u_d3 (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(irdy[1]), .in_data(in_data),
    .out_valid(ovld[1]), .out_ready(out_ready), .out_data(odat[1]),
    .count(cnt[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: a FIFO of accepted items stamped with their accept edge. The oldest item
  // reaches the last stage DEPTH-1 edges after acceptance, since everything ahead is empty.
  task automatic model_cycle(input int idx, input int dep, ref item_t q[$]);
    logic exp_ir;
    logic exp_ov;
    exp_ir = !flush && (q.size() < dep || out_ready);
    exp_ov = 1'b0;
    if (!flush && q.size() > 0) exp_ov = (cyc - q[0].t) >= dep - 1;
    chk($sformatf("d%0d in_ready", dep), 32'(irdy[idx]), 32'(exp_ir));
    chk($sformatf("d%0d count", dep), 32'(cnt[idx]), 32'(q.size()));
    chk($sformatf("d%0d out_valid", dep), 32'(ovld[idx]), 32'(exp_ov));
    if (exp_ov) chk($sformatf("d%0d out_data", dep), odat[idx], q[0].d);
    if (flush) begin
      q.delete();
    end else begin
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_ir) q.push_back('{d: in_data, t: cyc + 1});
    end
  endtask

  task automatic reset_checks(input int idx, input int dep);
    chk($sformatf("d%0d rst out_valid", dep), 32'(ovld[idx]), 32'd0);
    chk($sformatf("d%0d rst count", dep), 32'(cnt[idx]), 32'd0);
    chk($sformatf("d%0d rst out_data", dep), odat[idx], 32'd0);
    chk($sformatf("d%0d rst in_ready", dep), 32'(irdy[idx]), 32'(!flush));
  endtask

  // Monitor: samples on the falling edge, or just after an asynchronous reset assertion.
  always begin
    @(negedge clk or negedge rstn);
    if (!rstn) begin
      q0.delete();
      q1.delete();
      #1;
      reset_checks(0, 2);
      reset_checks(1, 3);
    end else begin
      model_cycle(0, 2, q0);
      model_cycle(1, 3, q1);
      cyc++;
      if (done) begin
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) drive(1'b0, 32'($urandom), ordy, 1'b0);
  endtask

  // Stimulus: directed scenarios followed by random traffic with backpressure and flushes.
  initial begin
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    // back-to-back fill with a free-running sink
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h11 + 32'(i), 1'b1, 1'b0);
    idle(4, 1'b1);
    // stall to full, then release
    drive(1'b1, 32'hA0, 1'b0, 1'b0);
    drive(1'b1, 32'hA1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hA2, 1'b0, 1'b0);
    drive(1'b1, 32'hA2, 1'b1, 1'b0);
    idle(5, 1'b1);
    // bubble collapse under a stalled sink
    drive(1'b1, 32'h1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h2, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(5, 1'b1);
    // flush against a full chain with both handshakes offered
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'hBF, 1'b1, 1'b1);
    idle(3, 1'b1);
    // asynchronous reset between edges while two items are held
    drive(1'b1, 32'hC0, 1'b0, 1'b0);
    drive(1'b1, 32'hC1, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hD0 + 32'(i), 1'b1, 1'b0);
    idle(4, 1'b1);
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(($urandom % 4) != 0, 32'($urandom), ($urandom % 3) != 0, ($urandom % 64) == 0);
    end
    idle(10, 1'b1);
    done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: monitor never reached the end of stimulus");
    $fatal(1);
  end

endmodule
